btn_conditioner: RTL

Conditions the OrangeCrab's raw `usr_btn` input and the board reset into the clean control signals the VGA demo core consumes. The block handles three jobs: synchronising and debouncing the button, generating a stretched active-low core reset, and turning a long button press into a soft reset of the demo. It sits between the board pins and the `pause_n`/`rst_n` inputs of the demo core, and replaces the ad-hoc power-on counter in the top level.

---
 rtl/btn_conditioner_pkg.sv | 31 +++
 rtl/btn_debounce.sv | 82 ++++++++
 rtl/btn_conditioner.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/btn_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// btn_conditioner_pkg
//
// Shared types and constants for the OrangeCrab button/reset conditioner.
//   - state_e          : long-press FSM states
//   - DEF_*            : default parameter values for a 48 MHz clock
//   - counter_width()  : width of a counter that must reach the larger of
//                        the long-press and debounce thresholds
// -----------------------------------------------------------------------------
package btn_conditioner_pkg;

   // 10 ms debounce, 2 s long press, short core-reset stretch at 48 MHz.
   localparam int DEF_DEBOUNCE_CYCLES   = 480000;
   localparam int DEF_LONG_PRESS_CYCLES = 96000000;
   localparam int DEF_RESET_CYCLES      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // button released (debounced)
      HELD = 2'd1,   // pressed, timing toward a long press
      LONG = 2'd2    // soft reset fired, waiting for release
   } state_e;

   // Width wide enough to count 0 .. max(long_c, deb_c)-1. Never returns 0,
   // so a degenerate parameter choice still yields a legal vector.
   function automatic int counter_width(input int long_c, input int deb_c);
      int top;
      top = (long_c > deb_c) ? long_c : deb_c;
      return (top > 2) ? $clog2(top) : 1;
   endfunction

endpackage : btn_conditioner_pkg

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Two-flop synchroniser followed by a consecutive-sample debouncer for the
// active-low user button. The debounced level only changes after
// DEBOUNCE_CYCLES consecutive synchronised samples disagree with it; any
// sample that agrees restarts the count.
//
// Ports:
//   clk48      in   system clock
//   rst        in   asynchronous active-high reset
//   usr_btn    in   raw button pin (asynchronous), 0 = pressed
//   btn_level  out  debounced level, 1 = released (registered)
//   press_evt  out  one-cycle strobe, registered together with btn_level
//                   falling to 0 (accepted press)
// -----------------------------------------------------------------------------
module btn_debounce
   import btn_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk48,
   input  logic rst,
   input  logic usr_btn,
   output logic btn_level,
   output logic press_evt
);

   localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;   // btn_s: the only copy later logic sees
   logic            level_q, level_d;
   logic            press_q, press_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path
      // through this block can leave a value unassigned and infer a latch.
      sync1_d  = usr_btn;
      sync2_d  = sync1_q;
      level_d  = level_q;
      db_cnt_d = db_cnt_q;
      press_d  = 1'b0;

      if (sync2_q == level_q) begin
         // Agreement (including a one-sample glitch back) restarts the count.
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         level_d  = sync2_q;
         db_cnt_d = '0;
         press_d  = ~sync2_q;
      end else begin
         db_cnt_d = db_cnt_q + DB_W'(1);
      end
   end

   // NOTE: the synchroniser and debounced level reset to 1 (released) so a
   // reset never looks like a press to the downstream FSM.
   always_ff @(posedge clk48 or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         level_q  <= 1'b1;
         press_q  <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         level_q  <= level_d;
         press_q  <= press_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   assign btn_level = level_q;
   assign press_evt = press_q;

endmodule : btn_debounce

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Conditions the OrangeCrab user button and board reset into the control
// inputs of the VGA demo core:
//   - synchronised, debounced button (btn_debounce sub-module)
//   - press / long-press FSM; a long press fires a soft reset of the demo
//   - stretched active-low core reset (board reset or soft reset)
//   - pause control
//
// Configuration macro: BTN_PAUSE_TOGGLE_EN
//   defined   : each accepted press toggles the pause state
//   undefined : pause_n follows the debounced button (paused while held)
//
// Ports:
//   clk48        in   48 MHz system clock
//   rst          in   asynchronous active-high reset
//   usr_btn      in   raw button pin, 0 = pressed
//   pause_n      out  demo core pause, 0 = paused (registered)
//   demo_rst_n   out  demo core reset, active-low (registered)
//   press_pulse  out  one-cycle strobe per accepted press (registered)
// -----------------------------------------------------------------------------
module btn_conditioner
   import btn_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
   parameter int RESET_CYCLES      = DEF_RESET_CYCLES
) (
   input  logic clk48,
   input  logic rst,
   input  logic usr_btn,
   output logic pause_n,
   output logic demo_rst_n,
   output logic press_pulse
);

   localparam int                HOLD_W    = counter_width(LONG_PRESS_CYCLES, DEBOUNCE_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
   localparam int                RST_W     = $clog2(RESET_CYCLES + 1);
   localparam logic [RST_W-1:0]  RST_LOAD  = RST_W'(RESET_CYCLES);

   // ---------------------------------------------------------------------
   // Synchroniser + debounce
   // ---------------------------------------------------------------------
   logic btn_level;   // debounced, 1 = released
   logic press_evt;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk48     (clk48),
      .rst       (rst),
      .usr_btn   (usr_btn),
      .btn_level (btn_level),
      .press_evt (press_evt)
   );

   // ---------------------------------------------------------------------
   // Press / long-press FSM
   // ---------------------------------------------------------------------
   state_e              state_q, state_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic                press_fire;
   logic                soft_fire;

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      press_fire = 1'b0;
      soft_fire  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (press_evt) begin
               state_d    = HELD;
               hold_cnt_d = '0;
               press_fire = 1'b1;
            end
         end
         HELD: begin
            // Release is tested first: a release coinciding with the
            // threshold must not fire a soft reset.
            if (btn_level) begin
               state_d = IDLE;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d   = LONG;
               soft_fire = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         LONG: begin
            // Only one soft reset per press; wait here for release.
            if (btn_level) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Core reset stretch
   // ---------------------------------------------------------------------
   logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
   logic             demo_rst_n_q, demo_rst_n_d;
   logic             press_pulse_q, press_pulse_d;

   always_comb begin
      // A soft reset during an active stretch reloads, never adds.
      if (soft_fire) begin
         rst_cnt_d = RST_LOAD;
      end else if (rst_cnt_q != '0) begin
         rst_cnt_d = rst_cnt_q - RST_W'(1);
      end else begin
         rst_cnt_d = '0;
      end

      // Registered from the current count, so the output lags the counter
      // by one cycle: low for exactly RESET_CYCLES cycles after a load.
      demo_rst_n_d  = (rst_cnt_q == '0);
      press_pulse_d = press_fire;
   end

   // ---------------------------------------------------------------------
   // Pause control
   // ---------------------------------------------------------------------
   logic pause_n_q, pause_n_d;

`ifdef BTN_PAUSE_TOGGLE_EN
   always_comb begin
      pause_n_d = pause_n_q;
      if (soft_fire) begin
         pause_n_d = 1'b1;
      end else if (press_fire) begin
         pause_n_d = ~pause_n_q;
      end
   end
`else
   // Paused only while the debounced button is held; a soft reset leaves it
   // alone and release brings pause_n back to 1.
   always_comb begin
      pause_n_d = btn_level;
   end
`endif

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk48 or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         hold_cnt_q    <= '0;
         rst_cnt_q     <= RST_LOAD;   // stretch begins counting when rst falls
         demo_rst_n_q  <= 1'b0;
         press_pulse_q <= 1'b0;
         pause_n_q     <= 1'b1;
      end else begin
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         rst_cnt_q     <= rst_cnt_d;
         demo_rst_n_q  <= demo_rst_n_d;
         press_pulse_q <= press_pulse_d;
         pause_n_q     <= pause_n_d;
      end
   end

   assign pause_n     = pause_n_q;
   assign demo_rst_n  = demo_rst_n_q;
   assign press_pulse = press_pulse_q;

endmodule : btn_conditioner
